// File: rtl/tdpsram.sv
// tdpsram - single-clock true-dual-port SRAM with per-byte write enables.
//
// Purpose: general storage primitive (cache tag/data arrays, predictor
// tables). Both ports can read and write every cycle. Read latency is 1 or
// 2 cycles, and the write mode is selectable:
//   write-first - a read returns the word as it is after this cycle's writes
//   read-first  - a read returns the word as it was before this cycle's writes
// When both ports write the same address in one cycle, port 1 wins on each
// byte lane that both ports enable.
//
// Optional feature macro: TDPSRAM_CLEAR_EN
//   defined   - a clear engine zeroes the array after reset and on clear_i.
//               ready_o is low while the sweep runs.
//   undefined - there is no clear engine, ready_o is always 1, clear_i is
//               unused, and array contents after reset are undefined.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   clear_i               request a full-array zero sweep
//   ready_o               array is accepting accesses
//   enN_i, weN_i          access enable; per-lane write enables
//   addrN_i, wdataN_i     word address; write data
//   rdataN_o, rvalidN_o   read data; read data valid (one pulse per access)
module tdpsram #(
  parameter int DATA_WIDTH   = 32,
  parameter int DATA_DEPTH   = 1024,
  parameter int BYTE_SIZE    = 8,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = 0,
  localparam int NB = DATA_WIDTH / BYTE_SIZE,
  localparam int AW = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  output logic                  ready_o,
  input  logic                  en0_i,
  input  logic [NB-1:0]         we0_i,
  input  logic [AW-1:0]         addr0_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  output logic                  rvalid0_o,
  input  logic                  en1_i,
  input  logic [NB-1:0]         we1_i,
  input  logic [AW-1:0]         addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic                  rvalid1_o
);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  logic          ready;
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          acc0, acc1, inr0, inr1, wr0, wr1;
  logic [DATA_WIDTH-1:0] rd0, rd1;

`ifdef TDPSRAM_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;
  localparam int CW = AW + 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep one word per cycle. clear_i is only looked at in RUN, so a
  // request made during a sweep does not restart it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (cnt_q == CW'(DATA_DEPTH - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        ready = 1'b1;
        if (clear_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign clr_addr = cnt_q[AW-1:0];
`else
  logic unused_clear;
  assign unused_clear = clear_i;
  assign ready        = 1'b1;
  assign clr_we       = 1'b0;
  assign clr_addr     = '0;
`endif

  assign ready_o = ready;
  assign acc0    = en0_i && ready;
  assign acc1    = en1_i && ready;
  // Addresses at or beyond DATA_DEPTH are legal to present: writes to them
  // are dropped and reads from them return zero.
  assign inr0    = {1'b0, addr0_i} < (AW+1)'(DATA_DEPTH);
  assign inr1    = {1'b0, addr1_i} < (AW+1)'(DATA_DEPTH);
  assign wr0     = acc0 && inr0;
  assign wr1     = acc1 && inr1;

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] base,
                                                  input logic [NB-1:0]         we,
                                                  input logic [DATA_WIDTH-1:0] wd);
    logic [DATA_WIDTH-1:0] r;
    r = base;
    for (int k = 0; k < NB; k++) begin
      if (we[k]) r[k*BYTE_SIZE +: BYTE_SIZE] = wd[k*BYTE_SIZE +: BYTE_SIZE];
    end
    return r;
  endfunction

  // Port 0 lanes are written first and port 1 lanes second, so port 1 wins
  // any lane that both ports write.
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_addr] <= '0;
    if (wr0) begin
      for (int k = 0; k < NB; k++) begin
        if (we0_i[k]) mem[addr0_i][k*BYTE_SIZE +: BYTE_SIZE] <= wdata0_i[k*BYTE_SIZE +: BYTE_SIZE];
      end
    end
    if (wr1) begin
      for (int k = 0; k < NB; k++) begin
        if (we1_i[k]) mem[addr1_i][k*BYTE_SIZE +: BYTE_SIZE] <= wdata1_i[k*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

  // In write-first mode the read word is the word as it will be after this
  // cycle's writes: the same merges, in the same order, as the array update.
  always_comb begin
    rd0 = inr0 ? mem[addr0_i] : '0;
    rd1 = inr1 ? mem[addr1_i] : '0;
    if (WRITE_MODE == 0) begin
      if (wr0)                        rd0 = merge(rd0, we0_i, wdata0_i);
      if (wr1 && addr1_i == addr0_i)  rd0 = merge(rd0, we1_i, wdata1_i);
      if (wr0 && addr0_i == addr1_i)  rd1 = merge(rd1, we0_i, wdata0_i);
      if (wr1)                        rd1 = merge(rd1, we1_i, wdata1_i);
    end
  end

  // The data registers load only on a valid access, so rdata holds its last
  // value while rvalid is low.
  logic                  v0_q, v1_q;
  logic [DATA_WIDTH-1:0] d0_q, d1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      d0_q <= '0;
      d1_q <= '0;
    end else begin
      v0_q <= acc0;
      v1_q <= acc1;
      if (acc0) d0_q <= rd0;
      if (acc1) d1_q <= rd1;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  v0_q2, v1_q2;
      logic [DATA_WIDTH-1:0] d0_q2, d1_q2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v0_q2 <= 1'b0;
          v1_q2 <= 1'b0;
          d0_q2 <= '0;
          d1_q2 <= '0;
        end else begin
          v0_q2 <= v0_q;
          v1_q2 <= v1_q;
          if (v0_q) d0_q2 <= d0_q;
          if (v1_q) d1_q2 <= d1_q;
        end
      end

      assign rvalid0_o = v0_q2;
      assign rvalid1_o = v1_q2;
      assign rdata0_o  = d0_q2;
      assign rdata1_o  = d1_q2;
    end else begin : g_lat1
      assign rvalid0_o = v0_q;
      assign rvalid1_o = v1_q;
      assign rdata0_o  = d0_q;
      assign rdata1_o  = d1_q;
    end
  endgenerate

endmodule
